// File: rtl/lstm_bptt_cell_pkg.sv
// lstm_bptt_cell_pkg: FSM encoding, fixed-point ONE and saturating add/subtract shared by the BPTT cell.
// Revision 1.0
`default_nettype none
package lstm_bptt_cell_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DELTA1 = 3'd1,
    DELTA2 = 3'd2,
    UPD    = 3'd3,
    BIAS   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int FRAC_BITS = 24;
  localparam logic signed [31:0] ONE = 32'sd1 <<< FRAC_BITS;

  // Operands arrive sign-extended to 64 bits, so the raw sum cannot wrap for w <= 62.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b, input int w);
    return sat_clamp(a + b, w);
  endfunction

  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b, input int w);
    return sat_clamp(a - b, w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lstm_bptt_cell_gate_upd.sv
// lstm_bptt_gate_upd: holds one gate's working weights/bias and applies w[k] -= LR*delta*x[k].
// Revision 1.0
`default_nettype none
module lstm_bptt_gate_upd
  import lstm_bptt_cell_pkg::*;
#(
  parameter int                      WIDTH = 32,
  parameter int                      NUM   = 3,
  parameter int                      FRAC  = 24,
  parameter int                      KW    = 2,
  parameter logic signed [WIDTH-1:0] LR    = 32'h0019_999A
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic [NUM*WIDTH-1:0]     i_w,
  input  logic signed [WIDTH-1:0]  i_b,
  input  logic                     i_upd,
  input  logic [KW-1:0]            i_k,
  input  logic signed [WIDTH-1:0]  i_x_k,
  input  logic signed [WIDTH-1:0]  i_delta,
  output logic [NUM*WIDTH-1:0]     o_w,
  output logic signed [WIDTH-1:0]  o_b_new
);
  logic signed [WIDTH-1:0] r_w [NUM];
  logic signed [WIDTH-1:0] r_b;
  logic signed [WIDTH-1:0] w_step;
  logic signed [WIDTH-1:0] w_dw;

  function automatic logic signed [WIDTH-1:0] fx_sub(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
    return WIDTH'(sat_sub(64'(a), 64'(b), WIDTH));
  endfunction

  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_step (.i_a(LR),     .i_b(i_delta), .o_p(w_step));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dw   (.i_a(w_step), .i_b(i_x_k),   .o_p(w_dw));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM; n++) r_w[n] <= '0;
      r_b <= '0;
    end else if (i_load) begin
      for (int n = 0; n < NUM; n++) r_w[n] <= i_w[n*WIDTH +: WIDTH];
      r_b <= i_b;
    end else if (i_upd) begin
      r_w[i_k] <= fx_sub(r_w[i_k], w_dw);
    end
  end

  for (genvar n = 0; n < NUM; n++) begin : g_pack
    assign o_w[n*WIDTH +: WIDTH] = r_w[n];
  end

  // Bias result is consumed combinationally on the BIAS cycle, so no bias write-back is needed.
  assign o_b_new = fx_sub(r_b, w_step);
endmodule
`default_nettype wire

// File: rtl/mult_2in.sv
// mult_2in: signed fixed-point multiply, full product shifted right by FRAC and truncated.
// Revision 1.0
`default_nettype none
module mult_2in #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_p
);
  assign o_p = WIDTH'(((2*WIDTH)'(i_a) * (2*WIDTH)'(i_b)) >>> FRAC);
endmodule
`default_nettype wire

// File: rtl/tanh.sv
// tanh: odd piecewise-linear tanh; identity below 0.5, slope 1/4 up to 2.5, then clamped at 1.0.
// Revision 1.0
`default_nettype none
module tanh #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic signed [WIDTH-1:0] i_x,
  output logic signed [WIDTH-1:0] o_y
);
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] C_HALF = C_ONE >> 1;
  localparam logic [WIDTH-1:0] C_KNEE = (C_ONE << 1) + C_HALF;
  localparam logic [WIDTH-1:0] C_OFS  = (C_ONE >> 2) + (C_ONE >> 3);

  logic             w_neg;
  logic [WIDTH-1:0] w_mag;
  logic [WIDTH-1:0] w_y;

  // Unsigned magnitude keeps the most negative input correct (2^(W-1) is past the knee).
  assign w_neg = i_x[WIDTH-1];
  assign w_mag = w_neg ? WIDTH'(-i_x) : i_x;

  always_comb begin
    if (w_mag < C_HALF)      w_y = w_mag;
    else if (w_mag < C_KNEE) w_y = (w_mag >> 2) + C_OFS;
    else                     w_y = C_ONE;
  end

  assign o_y = w_neg ? -$signed(w_y) : $signed(w_y);
endmodule
`default_nettype wire

// File: rtl/lstm_bptt_cell.sv
// lstm_bptt_cell: one LSTM BPTT step -- gate deltas, SGD weight/bias update and dc passed to t-1.
// Revision 1.0
`default_nettype none
module lstm_bptt_cell
  import lstm_bptt_cell_pkg::*;
#(
  parameter int                      WIDTH = 32,
  parameter int                      NUM   = 3,
  parameter int                      FRAC  = 24,
  parameter logic signed [WIDTH-1:0] LR    = 32'h0019_999A
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [NUM*WIDTH-1:0]    i_x,
  input  logic signed [WIDTH-1:0] i_a, i_i, i_f, i_o,
  input  logic signed [WIDTH-1:0] i_c, i_c_prev,
  input  logic signed [WIDTH-1:0] i_dh, i_dc_next,
  input  logic [NUM*WIDTH-1:0]    i_w_a, i_w_i, i_w_f, i_w_o,
  input  logic signed [WIDTH-1:0] i_b_a, i_b_i, i_b_f, i_b_o,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [NUM*WIDTH-1:0]    o_w_a, o_w_i, o_w_f, o_w_o,
  output logic [WIDTH-1:0]        o_b_a, o_b_i, o_b_f, o_b_o,
  output logic [WIDTH-1:0]        o_dc
);
  localparam int                      KW    = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic signed [WIDTH-1:0] C_ONE = WIDTH'(ONE);

  state_t                  r_state;
  logic [KW-1:0]           r_k;
  logic                    r_valid, r_ready;
  logic signed [WIDTH-1:0] r_a, r_i, r_f, r_o, r_c, r_cp, r_dh, r_dcn;
  logic signed [WIDTH-1:0] r_x [NUM];
  logic signed [WIDTH-1:0] r_dc, r_dcp, r_odc;
  logic signed [WIDTH-1:0] r_delta [4];
  logic [NUM*WIDTH-1:0]    r_ow [4];
  logic signed [WIDTH-1:0] r_ob [4];

  logic [NUM*WIDTH-1:0]    w_win [4];
  logic signed [WIDTH-1:0] w_bin [4];
  logic [NUM*WIDTH-1:0]    w_wout [4];
  logic signed [WIDTH-1:0] w_bnew [4];
  logic                    w_load, w_upd;
  logic signed [WIDTH-1:0] w_xk, w_tc, w_dc;
  logic signed [WIDTH-1:0] w_1mo, w_1mt, w_1ma, w_1mi, w_1mf;
  logic signed [WIDTH-1:0] w_p0, w_p1, w_p2, w_p3, w_p4, w_p5, w_p6, w_p7;
  logic signed [WIDTH-1:0] w_p8, w_p9, w_p10, w_p11, w_p12, w_p13, w_p14, w_p15;

  function automatic logic signed [WIDTH-1:0] fx_add(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
    return WIDTH'(sat_add(64'(a), 64'(b), WIDTH));
  endfunction

  function automatic logic signed [WIDTH-1:0] fx_sub(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
    return WIDTH'(sat_sub(64'(a), 64'(b), WIDTH));
  endfunction

  tanh #(.WIDTH(WIDTH), .FRAC(FRAC)) u_tanh (.i_x(r_c), .o_y(w_tc));

  // Products chain left to right, each truncated before the next multiply.
  assign w_1mo = fx_sub(C_ONE, r_o);
  assign w_1mt = fx_sub(C_ONE, w_p3);
  assign w_1ma = fx_sub(C_ONE, w_p7);
  assign w_1mi = fx_sub(C_ONE, r_i);
  assign w_1mf = fx_sub(C_ONE, r_f);
  assign w_dc  = fx_add(w_p5, r_dcn);

  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m0  (.i_a(r_dh),  .i_b(w_tc),  .o_p(w_p0));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m1  (.i_a(w_p0),  .i_b(r_o),   .o_p(w_p1));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m2  (.i_a(w_p1),  .i_b(w_1mo), .o_p(w_p2));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m3  (.i_a(w_tc),  .i_b(w_tc),  .o_p(w_p3));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m4  (.i_a(r_dh),  .i_b(r_o),   .o_p(w_p4));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m5  (.i_a(w_p4),  .i_b(w_1mt), .o_p(w_p5));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m6  (.i_a(r_dc),  .i_b(r_i),   .o_p(w_p6));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m7  (.i_a(r_a),   .i_b(r_a),   .o_p(w_p7));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m8  (.i_a(w_p6),  .i_b(w_1ma), .o_p(w_p8));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m9  (.i_a(r_dc),  .i_b(r_a),   .o_p(w_p9));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m10 (.i_a(w_p9),  .i_b(r_i),   .o_p(w_p10));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m11 (.i_a(w_p10), .i_b(w_1mi), .o_p(w_p11));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m12 (.i_a(r_dc),  .i_b(r_cp),  .o_p(w_p12));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m13 (.i_a(w_p12), .i_b(r_f),   .o_p(w_p13));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m14 (.i_a(w_p13), .i_b(w_1mf), .o_p(w_p14));
  mult_2in #(.WIDTH(WIDTH), .FRAC(FRAC)) u_m15 (.i_a(r_dc),  .i_b(r_f),   .o_p(w_p15));

  assign w_win[0] = i_w_a;  assign w_win[1] = i_w_i;  assign w_win[2] = i_w_f;  assign w_win[3] = i_w_o;
  assign w_bin[0] = i_b_a;  assign w_bin[1] = i_b_i;  assign w_bin[2] = i_b_f;  assign w_bin[3] = i_b_o;
  assign w_load   = (r_state == IDLE) && i_valid;
  assign w_upd    = (r_state == UPD);
  assign w_xk     = r_x[r_k];

  for (genvar g = 0; g < 4; g++) begin : g_gate
    lstm_bptt_gate_upd #(.WIDTH(WIDTH), .NUM(NUM), .FRAC(FRAC), .KW(KW), .LR(LR)) u_upd (
      .clk(clk), .rst(rst), .i_load(w_load), .i_w(w_win[g]), .i_b(w_bin[g]),
      .i_upd(w_upd), .i_k(r_k), .i_x_k(w_xk), .i_delta(r_delta[g]),
      .o_w(w_wout[g]), .o_b_new(w_bnew[g]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;  r_k <= '0;  r_valid <= 1'b0;  r_ready <= 1'b1;
      r_a <= '0;  r_i <= '0;  r_f <= '0;  r_o <= '0;
      r_c <= '0;  r_cp <= '0;  r_dh <= '0;  r_dcn <= '0;
      r_dc <= '0;  r_dcp <= '0;  r_odc <= '0;
      for (int n = 0; n < NUM; n++) r_x[n] <= '0;
      for (int g = 0; g < 4; g++) begin
        r_delta[g] <= '0;  r_ow[g] <= '0;  r_ob[g] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: if (i_valid) begin
          r_a <= i_a;  r_i <= i_i;  r_f <= i_f;  r_o <= i_o;
          r_c <= i_c;  r_cp <= i_c_prev;  r_dh <= i_dh;  r_dcn <= i_dc_next;
          for (int n = 0; n < NUM; n++) r_x[n] <= i_x[n*WIDTH +: WIDTH];
          r_ready <= 1'b0;
          r_state <= DELTA1;
        end
        DELTA1: begin
          r_delta[3] <= w_p2;
          r_dc       <= w_dc;
          r_state    <= DELTA2;
        end
        DELTA2: begin
          r_delta[0] <= w_p8;  r_delta[1] <= w_p11;  r_delta[2] <= w_p14;
          r_dcp      <= w_p15;
          r_k        <= '0;
          r_state    <= UPD;
        end
        UPD: begin
          if (r_k == KW'(NUM - 1)) r_state <= BIAS;
          else                     r_k <= r_k + KW'(1);
        end
        BIAS: begin
          // Results become visible only here so outputs hold the previous bundle until DONE.
          for (int g = 0; g < 4; g++) begin
            r_ow[g] <= w_wout[g];
            r_ob[g] <= w_bnew[g];
          end
          r_odc   <= r_dcp;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: if (i_ready) begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_dc    = r_odc;
  assign o_w_a = r_ow[0];  assign o_w_i = r_ow[1];  assign o_w_f = r_ow[2];  assign o_w_o = r_ow[3];
  assign o_b_a = r_ob[0];  assign o_b_i = r_ob[1];  assign o_b_f = r_ob[2];  assign o_b_o = r_ob[3];
endmodule
`default_nettype wire
